// File: rtl/add16_seq_ctrl_pkg.sv
// Shared constants for the wide sequential adder: slice width, FSM state
// encodings and the index-width helper.
package add16_pkg;

  localparam int unsigned W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count slices 0..words-1 (never less than one bit).
  function automatic int unsigned idx_w(input int unsigned words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/add16_seq_ctrl_if.sv
// Requester-side handshake and operand/result bus for add16_seq_ctrl.
// The sub port exists only when ADD16_SEQ_SUB_EN is defined.
interface add16_seq_ctrl_if
  import add16_pkg::*;
#(
  parameter int unsigned WORDS = 4
);

  localparam int unsigned OPW = W * WORDS;

  logic           start;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           cin;
`ifdef ADD16_SEQ_SUB_EN
  logic           sub;
`endif
  logic           ready;
  logic [OPW-1:0] sum;
  logic           cout;
  logic           done;

`ifdef ADD16_SEQ_SUB_EN
  modport master (output start, a, b, cin, sub, input ready, sum, cout, done);
  modport slave  (input start, a, b, cin, sub, output ready, sum, cout, done);
`else
  modport master (output start, a, b, cin, input ready, sum, cout, done);
  modport slave  (input start, a, b, cin, output ready, sum, cout, done);
`endif

endinterface

// File: rtl/add16_seq_ctrl_slice.sv
// Single combinational W-bit adder slice shared by all words of an operation.
module add16_slice
  import add16_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Full add with carry out in the top bit.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/add16_seq_ctrl.sv
// Wide (W*WORDS) adder built from one shared W-bit slice, one slice per
// clock, least significant word first, carry chained through a register.
// Optional subtract mode enabled by defining ADD16_SEQ_SUB_EN.
module add16_seq_ctrl
  import add16_pkg::*;
#(
  parameter int unsigned WORDS = 4
)(
  input logic                 clk,
  input logic                 rst,
  add16_seq_ctrl_if.slave     bus
);

  localparam int unsigned OPW   = W * WORDS;
  localparam int unsigned IDX_W = idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [OPW-1:0]   op_a_q, op_a_d;
  logic [OPW-1:0]   op_b_q, op_b_d;
  logic [OPW-1:0]   sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [W-1:0]     sl_a, sl_b, sl_sum;
  logic             sl_cout;

  // Current word of each latched operand feeds the shared slice.
  assign sl_a = op_a_q[idx_q*W +: W];
  assign sl_b = op_b_q[idx_q*W +: W];

  add16_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          carry_d = bus.cin;
`ifdef ADD16_SEQ_SUB_EN
          // A - B as A + ~B + 1; cin is not used for subtraction.
          if (bus.sub) begin
            op_b_d  = ~bus.b;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        sum_d[idx_q*W +: W] = sl_sum;
        carry_d             = sl_cout;
        idx_d               = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          // Final carry goes to cout only; it never wraps into slice 0.
          cout_d  = sl_cout;
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Scoreboard bench for add16_seq_ctrl (WORDS=4): directed cases plus random
// operands checked against a plain-arithmetic reference.
module tb_add16_seq_ctrl;
  import add16_pkg::*;

  localparam int unsigned WORDS = 4;
  localparam int unsigned OPW   = W * WORDS;

  typedef struct packed {
    logic           c;
    logic [OPW-1:0] s;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;
  int dones  = 0;
  int ops    = 0;

  res_t exp_q[$];

  add16_seq_ctrl_if #(.WORDS(WORDS)) bus ();

  add16_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [OPW:0] act, input logic [OPW:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: whole-operand arithmetic, no slicing.
  function automatic res_t model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    logic [OPW:0] t;
    if (sub) begin
      t   = {1'b0, a} - {1'b0, b};
      r.s = t[OPW-1:0];
      r.c = (a >= b);
    end else begin
      t   = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, cin};
      r.s = t[OPW-1:0];
      r.c = t[OPW];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready, present one request, push its expected result.
  task automatic start_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                          input logic cin, input logic sub);
    int n = 0;
    while (!bus.ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0, required 1 within 100 cycles");
    end
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef ADD16_SEQ_SUB_EN
    bus.sub = sub;
`endif
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exp_q.push_back(model(a, b, cin, sub));
    ops++;
    // Operands may change freely once accepted.
    bus.a   = OPW'({$urandom, $urandom});
    bus.b   = OPW'({$urandom, $urandom});
    bus.cin = 1'($urandom);
`ifdef ADD16_SEQ_SUB_EN
    bus.sub = 1'($urandom);
`endif
  endtask

  // Wait until all outstanding results have been checked, then one more cycle.
  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending results, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  initial begin
    logic prev_done = 1'b0;
    res_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, required no pending op");
        end else begin
          e = exp_q.pop_front();
          check("sum", {1'b0, bus.sum}, {1'b0, e.s});
          check("cout", {{OPW{1'b0}}, bus.cout}, {{OPW{1'b0}}, e.c});
        end
        if (prev_done) begin
          checks++;
          errors++;
          $display("FAIL done_width: got done high 2 cycles, required 1");
        end
      end
      prev_done = bus.done;
    end
  end

  // Watchdog against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OPW-1:0] ones;
    int d0;
    ones = '1;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef ADD16_SEQ_SUB_EN
    bus.sub   = 1'b0;
`endif
    step();
    step();
    check("rst_ready", {{OPW{1'b0}}, bus.ready}, 1);
    check("rst_done", {{OPW{1'b0}}, bus.done}, 0);
    check("rst_sum", {1'b0, bus.sum}, 0);
    check("rst_cout", {{OPW{1'b0}}, bus.cout}, 0);
    rst = 1'b0;
    step();

    // Basic add with handshake timing: done exactly after edge WORDS.
    start_op(OPW'(3), OPW'(2), 1'b0, 1'b0);
    check("busy_ready", {{OPW{1'b0}}, bus.ready}, 0);
    repeat (WORDS) step();
    check("lat_done", {{OPW{1'b0}}, bus.done}, 1);
    check("lat_ready", {{OPW{1'b0}}, bus.ready}, 0);
    step();
    check("post_done", {{OPW{1'b0}}, bus.done}, 0);
    check("post_ready", {{OPW{1'b0}}, bus.ready}, 1);

    // Full carry chains.
    start_op(ones, ones, 1'b0, 1'b0);
    wait_done();
    start_op(ones, OPW'(0), 1'b1, 1'b0);
    wait_done();

    // Carry from slice 0 must reach slice 1 (observed in the partial sum).
    start_op(OPW'(64'hFFFF), OPW'(1), 1'b0, 1'b0);
    step();
    step();
    check("partial_sum", {1'b0, bus.sum}, {1'b0, OPW'(64'h1_0000)});
    wait_done();

    // Start during RUN and DONE is ignored.
    d0 = dones;
    start_op(OPW'(7), OPW'(8'h23), 1'b0, 1'b0);
    step();
    step();
    step();
    bus.start = 1'b1;
    bus.a     = OPW'(64'h1234);
    bus.b     = OPW'(64'h5678);
    step();
    check("ign_done", {{OPW{1'b0}}, bus.done}, 1);
    step();
    bus.start = 1'b0;
    check("ign_ready", {{OPW{1'b0}}, bus.ready}, 1);
    step();
    step();
    check("ign_idle", {{OPW{1'b0}}, bus.ready}, 1);
    check("ign_one_done", OPW'(dones - d0), 1);

    // Reset in RUN at idx=2 aborts with no done pulse.
    start_op(OPW'({$urandom, $urandom}), OPW'({$urandom, $urandom}), 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_back());
    ops--;
    check("abort_sum", {1'b0, bus.sum}, 0);
    check("abort_cout", {{OPW{1'b0}}, bus.cout}, 0);
    check("abort_done", {{OPW{1'b0}}, bus.done}, 0);
    check("abort_ready", {{OPW{1'b0}}, bus.ready}, 1);
    d0 = dones;
    repeat (8) step();
    check("abort_no_done", OPW'(dones - d0), 0);
    start_op(OPW'(64'h1003), OPW'(3), 1'b1, 1'b0);
    wait_done();

`ifdef ADD16_SEQ_SUB_EN
    start_op(OPW'(5), OPW'(3), 1'b0, 1'b1);
    wait_done();
    start_op(OPW'(3), OPW'(5), 1'b1, 1'b1);
    wait_done();
`endif

    // Random back-to-back operations.
    for (int i = 0; i < 24; i++) begin
      logic sub;
`ifdef ADD16_SEQ_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      start_op(OPW'({$urandom, $urandom}), OPW'({$urandom, $urandom}), 1'($urandom), sub);
    end
    wait_done();

    check("done_count", OPW'(dones), OPW'(ops));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
